// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Computes the low word of a MUL by driving the shared ALU through
//            repeated ADDs in shift-add order. MUL_EARLY_EXIT_EN ends the run
//            once the remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    input  logic            flush,
    output logic            busy,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result
);

    localparam int              CNT_W    = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(XLEN - 1);
    localparam logic [3:0]      C_ALU_ADD = 4'b0010;
    localparam logic [3:0]      C_ALU_NOP = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;

    logic [XLEN-1:0]   w_acc_next;
    logic [XLEN-1:0]   w_mplier_next;
    logic              w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            out_result_q <= out_result_d;
        end
    end

    // The ALU sees acc/mcand and returns their sum; take it only when the
    // current multiplier bit is set.
    always_comb begin
        w_acc_next    = mplier_q[0] ? alu_result : acc_q;
        w_mplier_next = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
        w_last        = (cnt_q == C_LAST) || (w_mplier_next == '0);
`else
        w_last        = (cnt_q == C_LAST);
`endif
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        out_result_d = out_result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        acc_d    = '0;
                        mcand_d  = in_a;
                        mplier_d = in_b;
                        cnt_d    = '0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d    = w_acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = w_mplier_next;
                    cnt_d    = cnt_q + 1'b1;
                    if (w_last) begin
                        out_result_d = w_acc_next;
                        state_d      = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q == S_RUN);
    assign out_result = out_result_q;
    assign alu_a      = acc_q;
    assign alu_b      = mcand_q;
    assign alu_ctrl   = (state_q == S_RUN) ? C_ALU_ADD : C_ALU_NOP;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Directed and randomized checks of alu_mul_sequencer against a
//            product/latency reference model, with a behavioural ALU attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;

    int n_pass  = 0;
    int n_total = 0;

    alu_mul_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .flush      (flush),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU: AND/OR/ADD/SUB decoded from Control_in.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return p[31:0];
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
        int l;
        l = 32;
`ifdef MUL_EARLY_EXIT_EN
        l = 1;
        for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
`endif
        return l;
    endfunction

    // Issues one request, checks latency, result, backpressure and handshake.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int hold);
        int          cyc;
        int          bad;
        logic [31:0] res0;
        cyc = 0;
        while (!in_ready && cyc < 100) begin step(); cyc++; end
        check({tag, ":ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        check({tag, ":alu_a_start"}, alu_a, 32'h0);
        check({tag, ":alu_b_start"}, alu_b, a);
        cyc = 0;
        bad = 0;
        while (!out_valid && cyc < 100) begin
            if (!busy || alu_ctrl !== 4'b0010 || in_ready) bad++;
            step();
            cyc++;
        end
        check({tag, ":run_outputs"}, 32'(bad), 32'd0);
        check({tag, ":latency"}, 32'(cyc), 32'(ref_latency(b)));
        check({tag, ":result"}, out_result, ref_product(a, b));
        check({tag, ":ctrl_done"}, {28'h0, alu_ctrl}, 32'h0);
        res0 = out_result;
        bad  = 0;
        for (int k = 0; k < hold; k++) begin
            if (out_result !== res0 || in_ready || !out_valid || busy) bad++;
            step();
        end
        check({tag, ":hold_stable"}, 32'(bad), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ":ready_after"}, {30'h0, in_ready, out_valid}, 32'h2);
    endtask

    initial begin
        int          cyc;
        int          seen;
        logic [31:0] ra;
        logic [31:0] rb;

        #2;
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_flags", {30'h0, out_valid, busy}, 32'h0);
        check("reset_alu", alu_a | alu_b | {28'h0, alu_ctrl}, 32'h0);
        check("reset_result", out_result, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        run_mul("3x5", 32'd3, 32'd5, 0);
        run_mul("ff_x_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_mul("b_zero", 32'h1234_5678, 32'h0, 2);
        run_mul("bp10", 32'hDEAD_BEEF, 32'h0000_0F0F, 10);
        run_mul("b2b_7x6", 32'd7, 32'd6, 0);

        // Flush mid-run: never produces a result.
        in_valid = 1'b1; in_a = 32'h0001_0000; in_b = 32'h0001_0000;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", {29'h0, in_ready, out_valid, busy}, 32'h4);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen++;
            step();
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        run_mul("post_flush_2x2", 32'd2, 32'd2, 0);

        // Flush beats a simultaneous request in IDLE.
        in_valid = 1'b1; flush = 1'b1; in_a = 32'd4; in_b = 32'd4;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept", {30'h0, in_ready, busy}, 32'h2);

        // Asynchronous reset in the middle of a run.
        in_valid = 1'b1; in_a = 32'h0000_0123; in_b = 32'hF000_0001;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("prereset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_flags", {29'h0, in_ready, out_valid, busy}, 32'h4);
        check("midreset_alu", alu_a | alu_b | {28'h0, alu_ctrl}, 32'h0);
        check("midreset_result", out_result, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        run_mul("post_reset_9x9", 32'd9, 32'd9, 0);

        for (int t = 0; t < 20; t++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_mul($sformatf("rand%0d", t), ra, rb, int'($urandom_range(0, 3)));
        end

        cyc = 0;
        while (!in_ready && cyc < 10) begin step(); cyc++; end
        check("final_idle", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle sequencer that implements RV32M MUL (low 32 bits of the product) by driving the single shared ALU through repeated ADD operations in shift-add order. It sits between the execute-stage issue logic and the ALU: while busy it owns the ALU's A, B and Control_in inputs and consumes ALU_Result. Operands arrive on a valid/ready request channel and results leave on a valid/ready response channel.

## Interface

Parameters:
- XLEN, 32, operand/result width; the counter is clog2(XLEN)+1 bits wide.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request ready; equals (state==IDLE).
- in_a  input  XLEN  multiplicand.
- in_b  input  XLEN  multiplier.
- out_valid  output  1  result valid; equals (state==DONE).
- out_ready  input  1  consumer accepts the result.
- out_result  output  XLEN  product mod 2^XLEN; registered.
- flush  input  1  synchronous abort.
- busy  output  1  equals (state==RUN); the ALU must not be granted elsewhere while high.
- alu_a  output  XLEN  driven to the ALU A input (acc register).
- alu_b  output  XLEN  driven to the ALU B input (mcand register).
- alu_ctrl  output  4  driven to ALU Control_in: 4'b0010 (ADD) in RUN, 4'b0000 otherwise.
- alu_result  input  XLEN  ALU_Result returned from the ALU, combinational from alu_a/alu_b/alu_ctrl.

## Operation

- Registers: state, acc, mcand, mplier, cnt, out_result.
- IDLE: when in_valid is high, the block accepts the request. It sets acc←0, mcand←in_a, mplier←in_b, cnt←0, and moves to RUN.
- RUN, each edge:
  - If mplier[0] is 1, acc←alu_result (acc+mcand); otherwise acc is held.
  - mcand←mcand<<1 (zero fill), mplier←mplier>>1 (logical), cnt←cnt+1.
  - When cnt==XLEN-1, out_result←next acc and the block moves to DONE.
- DONE: out_valid is high and out_result is stable. When out_ready is high, the block moves to IDLE. The next request is accepted no earlier than the following edge; there is no same-cycle re-accept.
- All arithmetic is modulo 2^XLEN. Signedness does not matter for the low word, and carries out of the ALU are discarded. The ALU zero output is unused.
- flush: at the next edge, any state moves to IDLE and out_valid is never raised for the aborted request. flush has priority over acceptance, RUN completion and out_ready.
- Reset, asynchronous and including mid-operation: state=IDLE and acc, mcand, mplier, cnt, out_result = 0.
  - Resulting outputs during and after reset: in_ready=1, out_valid=0, busy=0, alu_a=0, alu_b=0, alu_ctrl=4'b0000.

## Timing

- The acceptance edge is E0. RUN occupies the cycles E0→E1 through E(XLEN-1)→E(XLEN).
- out_valid rises at edge XLEN after E0, so the latency is 32 cycles for XLEN=32. This is the default build; early exit changes it (see Configuration).
- out_valid stays high with out_result stable until the edge where out_ready=1. in_ready is high from the next edge.
- in_a/in_b are sampled only at the acceptance edge. Changes afterwards are ignored.
- alu_a/alu_b/alu_ctrl are registered-state-derived and stable for the whole cycle. The combinational path runs acc/mcand → ALU → alu_result → acc and must close within one cycle.
- Simultaneous in_valid and flush in IDLE: the request is not accepted and in_ready stays 1.

## Configuration

- MUL_EARLY_EXIT_EN, defined:
  - In RUN, if the next mplier value (mplier>>1) is zero, out_result←next acc and the block moves to DONE on that edge.
  - Latency = max(1, bit index of the most-significant 1 in in_b, plus 1). in_b=0 gives latency 1.
- MUL_EARLY_EXIT_EN, undefined: RUN always lasts exactly XLEN cycles. The result is identical in both builds.

## Test plan

- Reset, then in_a=3, in_b=5 → out_result=15.
  - Without the macro, out_valid at E32.
  - With the macro, out_valid at E3.
- in_a=in_b=0xFFFFFFFF → out_result=0x00000001, with out_valid at E32 in both builds.
- in_a=0x12345678, in_b=0 → out_result=0.
  - With the macro, latency is 1.
  - alu_ctrl=4'b0010 only during RUN cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, then 1.
  - out_result stays stable and in_ready stays 0 throughout.
  - in_ready=1 the cycle after the handshake.
  - A back-to-back second request, 7×6, returns 42.
- Flush at E10 of 0x10000×0x10000 → IDLE at E11, out_valid never asserted. A following 2×2 returns 4.
- rst_n low at E5 of a RUN → all outputs take reset values immediately (in_ready=1). After release, 9×9 returns 81.
